// File: rtl/div_if.sv
// Request/response bundle between the EXE stage and the iterative divider.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider, one quotient bit per cycle, signed/unsigned,
// result {remainder, quotient} held until the requester drops start_i.
module div_unit (
  input  logic clk,
  input  logic resetn,
  div_if.slave bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BYZERO, ST_ON, ST_END} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  dvd;
  logic [W-1:0]    dvs;
  logic            neg_q;
  logic            neg_r;
  logic [2*W-1:0]  result;
  logic            ready;
  logic            busy;

  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;
  logic [2*W:0]    sh;
  logic            ge;
  logic [2*W-1:0]  dvd_nxt;
  logic [W-1:0]    q_fin;
  logic [W-1:0]    r_fin;

  // Operand magnitudes for the unsigned core
  always_comb begin
    a_neg = bus.signed_div_i & bus.opdata1_i[W-1];
    b_neg = bus.signed_div_i & bus.opdata2_i[W-1];
    a_mag = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    b_mag = b_neg ? -bus.opdata2_i : bus.opdata2_i;
  end

  // One restoring step; the compare stands in for the borrow of the trial subtract
  always_comb begin
    sh      = {dvd, 1'b0};
    ge      = (sh[2*W:W] >= {1'b0, dvs});
    dvd_nxt = sh[2*W-1:0];
    if (ge) begin
      dvd_nxt = {sh[2*W-1:W] - dvs, sh[W-1:1], 1'b1};
    end
    q_fin = neg_q ? -dvd_nxt[W-1:0]   : dvd_nxt[W-1:0];
    r_fin = neg_r ? -dvd_nxt[2*W-1:W] : dvd_nxt[2*W-1:W];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            dvd   <= {{W{1'b0}}, a_mag};
            dvs   <= b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (bus.opdata2_i == '0) ? ST_BYZERO : ST_ON;
          end
        end
        ST_BYZERO: begin
          busy   <= 1'b0;
          result <= '0;
          if (bus.annul_i) begin
            ready <= 1'b0;
            state <= ST_IDLE;
          end else begin
            ready <= 1'b1;
            state <= ST_END;
          end
        end
        ST_ON: begin
          // Flush wins over a completion landing on the same edge
          if (bus.annul_i) begin
            cnt    <= '0;
            busy   <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
            state  <= ST_IDLE;
          end else begin
            dvd <= dvd_nxt;
            if (cnt == LAST_STEP) begin
              cnt    <= '0;
              busy   <= 1'b0;
              ready  <= 1'b1;
              result <= {r_fin, q_fin};
              state  <= ST_END;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        ST_END: begin
          if (bus.annul_i || !bus.start_i) begin
            ready  <= 1'b0;
            result <= '0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = busy;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results are queued at request time
// and popped when ready_o rises.
module tb_div_unit;
  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  div_if bus ();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic avoids the -2^31/-1 overflow of 32-bit signed
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sd = longint'({32'd0, b});
    end
    q = sa / sd;
    r = sa % sd;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int   n;
    bit   got;
    exp_t e;
    int   lat;
    lat = (b == 32'd0) ? 2 : 33;
    sbq.push_back('{tag, exp});
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
      if (bus.ready_o) got = 1'b1;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_busy_at_ready"}, 64'(bus.busy_o), 64'd0);
    e = sbq.pop_front();
    chk(e.tag, bus.result_o, e.val);
    // Operand changes after acceptance must not disturb the held result
    bus.opdata1_i = ~a;
    bus.opdata2_i = 32'd0;
    @(negedge clk);
    chk({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_hold_result"}, bus.result_o, exp);
    bus.start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_drop_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_drop_result"}, bus.result_o, 64'd0);
  endtask

  task automatic do_annul(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int wait_n);
    bit seen;
    @(negedge clk);
    bus.signed_div_i = s;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    repeat (wait_n) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_ready"}, 64'(bus.ready_o), 64'd0);
    chk({tag, "_result"}, bus.result_o, 64'd0);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.ready_o;
    end
    chk({tag, "_no_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    bit seen;
    resetn           = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    resetn = 1'b1;

    do_div("u_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    do_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    do_div("u_div0", 1'b0, 32'd1234, 32'd0, 64'd0);
    do_div("s_div0", 1'b1, 32'hFFFFFFF0, 32'd0, 64'd0);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, model(1'b1, 32'd7, 32'hFFFFFFFE));
    do_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, model(1'b0, 32'hFFFFFFFF, 32'd1));
    do_div("u_small_big", 1'b0, 32'd5, 32'hFFFFFFFF, model(1'b0, 32'd5, 32'hFFFFFFFF));
    do_div("u_vs_s", 1'b0, 32'h80000000, 32'hFFFFFFFF, model(1'b0, 32'h80000000, 32'hFFFFFFFF));
    for (int i = 0; i < 4; i++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(1, 0));
      a = $urandom;
      b = $urandom;
      if (i == 3) b = b >> 20;
      if (b == 32'd0) b = 32'd3;
      do_div($sformatf("rnd%0d", i), s, a, b, model(s, a, b));
    end

    do_annul("annul_step10", 1'b0, 32'hFFFFFFFF, 32'd3, 11);
    do_div("u_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
    do_annul("annul_last_step", 1'b0, 32'd100, 32'd7, 32);
    do_annul("annul_byzero", 1'b1, 32'd5, 32'd0, 1);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (21) @(negedge clk);
    chk("mid_busy_pre_reset", 64'(bus.busy_o), 64'd1);
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.busy_o), 64'd0);
    chk("async_rst_ready", 64'(bus.ready_o), 64'd0);
    chk("async_rst_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    resetn      = 1'b1;
    seen        = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.ready_o;
    end
    chk("rst_no_ready", 64'(seen), 64'd0);
    do_div("post_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
